vga_box_plotter: RTL and testbench

- Parametrised successor to the fixed 4x4 draw/erase sprite FSM.
- Plots a BOX_W x BOX_H filled rectangle at a latched origin into the VGA pixel interface (oX/oY/oColour/oPlot).
- Three modes: draw only, erase only (colour 0), and draw-then-erase with a programmable hold gap.
- Sits between game/animation control logic and the VGA adapter; uses a start/busy/done handshake instead of a free-running load strobe.

---
 rtl/vga_box_plotter.sv | 188 ++++++++++++++++++
 tb/tb_vga_box_plotter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_box_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_box_plotter
//  Description : Plots a BOX_W x BOX_H filled rectangle at a latched origin
//                into the VGA pixel interface (oX/oY/oColour/oPlot).
//                Modes: 0/3 = draw, 1 = erase (colour 0),
//                2 = draw, hold HOLD_CYCLES idle cycles, then erase.
//                start/busy/done handshake towards the control logic.
//  Optional    : `define VGA_BOX_PLOTTER_CLIP_EN suppresses oPlot for
//                pixels at or beyond SCREEN_W/SCREEN_H instead of wrapping.
//  Ports       : iClock  - clock, rising edge
//                iResetn - asynchronous active-low reset
//                iStart  - operation request, sampled only when idle
//                iMode   - operation mode (latched in LOAD)
//                iX/iY   - box origin, left/top (latched in LOAD)
//                iColour - draw colour (latched in LOAD)
//                oX/oY/oColour/oPlot - registered pixel write port
//                oBusy   - operation in progress
//                oDone   - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_box_plotter #(
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COL_W       = 3,
  parameter int BOX_W       = 4,
  parameter int BOX_H       = 4,
  parameter int HOLD_CYCLES = 0,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120
) (
  input  logic             iClock,
  input  logic             iResetn,
  input  logic             iStart,
  input  logic [1:0]       iMode,
  input  logic [X_W-1:0]   iX,
  input  logic [Y_W-1:0]   iY,
  input  logic [COL_W-1:0] iColour,
  output logic [X_W-1:0]   oX,
  output logic [Y_W-1:0]   oY,
  output logic [COL_W-1:0] oColour,
  output logic             oPlot,
  output logic             oBusy,
  output logic             oDone
);

  // Counter widths never drop below one bit so degenerate sizes still elaborate.
  localparam int C_COL_W  = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int C_ROW_W  = (BOX_H > 1) ? $clog2(BOX_H) : 1;
  localparam int C_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [C_COL_W-1:0]  C_COL_LAST  = C_COL_W'(BOX_W - 1);
  localparam logic [C_ROW_W-1:0]  C_ROW_LAST  = C_ROW_W'(BOX_H - 1);
  localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(HOLD_CYCLES - 1);

  // Screen bounds only matter when clipping is built in.
  localparam int c_unused_screen = SCREEN_W + SCREEN_H;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAW  = 3'd2,
    S_HOLD  = 3'd3,
    S_ERASE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               r_state;
  logic [X_W-1:0]       r_x0;
  logic [Y_W-1:0]       r_y0;
  logic [COL_W-1:0]     r_colour;
  logic [1:0]           r_mode;
  logic [C_COL_W-1:0]   r_col;
  logic [C_ROW_W-1:0]   r_row;
  logic [C_HOLD_W-1:0]  r_hold;
  logic [X_W-1:0]       r_x;
  logic [Y_W-1:0]       r_y;
  logic [COL_W-1:0]     r_colour_out;
  logic                 r_plot;
  logic                 r_busy;
  logic                 r_done;

  logic [X_W-1:0]       w_px;
  logic [Y_W-1:0]       w_py;
  logic                 w_vis;
  logic                 w_last;

`ifdef VGA_BOX_PLOTTER_CLIP_EN
  // One extra bit keeps the carry so off-screen pixels are detected, not wrapped.
  logic [X_W:0] w_sx;
  logic [Y_W:0] w_sy;
  assign w_sx  = {1'b0, r_x0} + (X_W+1)'(r_col);
  assign w_sy  = {1'b0, r_y0} + (Y_W+1)'(r_row);
  assign w_px  = w_sx[X_W-1:0];
  assign w_py  = w_sy[Y_W-1:0];
  assign w_vis = (w_sx < (X_W+1)'(SCREEN_W)) && (w_sy < (Y_W+1)'(SCREEN_H));
`else
  assign w_px  = r_x0 + X_W'(r_col);
  assign w_py  = r_y0 + Y_W'(r_row);
  assign w_vis = 1'b1;
`endif

  assign w_last = (r_col == C_COL_LAST) && (r_row == C_ROW_LAST);

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      r_state      <= S_IDLE;
      r_x0         <= '0;
      r_y0         <= '0;
      r_colour     <= '0;
      r_mode       <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_hold       <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_colour_out <= '0;
      r_plot       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // Status outputs are a registered decode of the state just left.
      r_plot <= 1'b0;
      r_done <= 1'b0;
      r_busy <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (iStart) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_x0     <= iX;
          r_y0     <= iY;
          r_colour <= iColour;
          r_mode   <= iMode;
          r_col    <= '0;
          r_row    <= '0;
          r_state  <= (iMode == 2'd1) ? S_ERASE : S_DRAW;
        end
        S_DRAW, S_ERASE: begin
          r_x          <= w_px;
          r_y          <= w_py;
          r_colour_out <= (r_state == S_DRAW) ? r_colour : '0;
          r_plot       <= w_vis;
          if (w_last) begin
            r_col <= '0;
            r_row <= '0;
            if (r_state == S_ERASE || r_mode != 2'd2) begin
              r_state <= S_DONE;
            end else if (HOLD_CYCLES > 0) begin
              r_hold  <= '0;
              r_state <= S_HOLD;
            end else begin
              r_state <= S_ERASE;
            end
          end else if (r_col == C_COL_LAST) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        S_HOLD: begin
          if (r_hold == C_HOLD_LAST) begin
            r_col   <= '0;
            r_row   <= '0;
            r_state <= S_ERASE;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oX      = r_x;
  assign oY      = r_y;
  assign oColour = r_colour_out;
  assign oPlot   = r_plot;
  assign oBusy   = r_busy;
  assign oDone   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vga_box_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_box_plotter
//  Description : Directed self-checking bench for vga_box_plotter. Three
//                instances: defaults (d0), HOLD_CYCLES=3 (d1), 3x2 box (d2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_box_plotter;

  logic       clk;
  logic       rst_n;
  logic [2:0] start;
  logic [1:0] mode;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] col_in;

  logic [7:0] ox    [3];
  logic [6:0] oy    [3];
  logic [2:0] ocol  [3];
  logic       oplot [3];
  logic       obusy [3];
  logic       odone [3];

  int n_checks = 0;
  int n_errors = 0;

  vga_box_plotter u_d0 (
    .iClock(clk), .iResetn(rst_n), .iStart(start[0]), .iMode(mode),
    .iX(x_in), .iY(y_in), .iColour(col_in),
    .oX(ox[0]), .oY(oy[0]), .oColour(ocol[0]), .oPlot(oplot[0]),
    .oBusy(obusy[0]), .oDone(odone[0])
  );

  vga_box_plotter #(.HOLD_CYCLES(3)) u_d1 (
    .iClock(clk), .iResetn(rst_n), .iStart(start[1]), .iMode(mode),
    .iX(x_in), .iY(y_in), .iColour(col_in),
    .oX(ox[1]), .oY(oy[1]), .oColour(ocol[1]), .oPlot(oplot[1]),
    .oBusy(obusy[1]), .oDone(odone[1])
  );

  vga_box_plotter #(.BOX_W(3), .BOX_H(2)) u_d2 (
    .iClock(clk), .iResetn(rst_n), .iStart(start[2]), .iMode(mode),
    .iX(x_in), .iY(y_in), .iColour(col_in),
    .oX(ox[2]), .oY(oy[2]), .oColour(ocol[2]), .oPlot(oplot[2]),
    .oBusy(obusy[2]), .oDone(odone[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {done, busy, plot}
  task automatic check_flags(input string tag, input int d, input logic [2:0] exp);
    check(tag, {29'd0, odone[d], obusy[d], oplot[d]}, {29'd0, exp});
  endtask

  function automatic logic exp_vis(input int px, input int py);
`ifdef VGA_BOX_PLOTTER_CLIP_EN
    return (px < 160) && (py < 120);
`else
    return 1'b1;
`endif
  endfunction

  // One pass of bw*bh raster pixels, one per cycle.
  task automatic expect_pass(input string tag, input int d, input int x0, input int y0,
                             input int c, input int bw, input int bh);
    for (int r = 0; r < bh; r++) begin
      for (int k = 0; k < bw; k++) begin
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        step();
        ex = 8'((x0 + k) & 255);
        ey = 7'((y0 + r) & 127);
        ec = 3'(c);
        check_flags({tag, " flags"}, d, {1'b0, 1'b1, exp_vis(x0 + k, y0 + r)});
        check({tag, " pixel"}, {14'd0, ox[d], oy[d], ocol[d]}, {14'd0, ex, ey, ec});
      end
    end
  endtask

  // Called just after the edge that sampled iStart.
  task automatic expect_op(input int d, input int m, input int x0, input int y0,
                           input int c, input int bw, input int bh, input int hold);
    int mm;
    mm = (m == 3) ? 0 : m;
    step();
    check_flags("load", d, 3'b010);
    if (mm != 1) expect_pass("draw", d, x0, y0, c, bw, bh);
    if (mm == 2) begin
      for (int h = 0; h < hold; h++) begin
        step();
        check_flags("hold gap", d, 3'b010);
      end
    end
    if (mm != 0) expect_pass("erase", d, x0, y0, 0, bw, bh);
    step();
    check_flags("done", d, 3'b110);
    step();
    check_flags("idle after done", d, 3'b000);
  endtask

  task automatic launch(input int d, input int m, input int x0, input int y0,
                        input int c, input bit keep);
    @(negedge clk);
    mode     = 2'(m);
    x_in     = 8'(x0);
    y_in     = 7'(y0);
    col_in   = 3'(c);
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) start[d] = 1'b0;
  endtask

  initial begin
    logic any_activity;
    rst_n  = 1'b0;
    start  = 3'b000;
    mode   = 2'd0;
    x_in   = 8'd0;
    y_in   = 7'd0;
    col_in = 3'd0;
    #2;
    for (int d = 0; d < 3; d++) begin
      check_flags("reset flags", d, 3'b000);
      check("reset pixel", {14'd0, ox[d], oy[d], ocol[d]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Default draw.
    launch(0, 0, 10, 20, 5, 1'b0);
    expect_op(0, 0, 10, 20, 5, 4, 4, 0);

    // Draw, hold 3, erase.
    launch(1, 2, 0, 0, 7, 1'b0);
    expect_op(1, 2, 0, 0, 7, 4, 4, 3);

    // 3x2 erase.
    launch(2, 1, 100, 50, 3, 1'b0);
    expect_op(2, 1, 100, 50, 3, 3, 2, 0);

    // iStart held, iX changed mid-pass: second op only after done.
    launch(0, 0, 30, 40, 2, 1'b1);
    fork
      expect_op(0, 0, 30, 40, 2, 4, 4, 0);
      begin
        @(posedge clk);
        #2 x_in = 8'd90;
        repeat (18) @(posedge clk);
        #2 start[0] = 1'b0;
      end
    join
    expect_op(0, 0, 90, 40, 2, 4, 4, 0);

    // Asynchronous reset mid-draw.
    launch(0, 0, 5, 5, 1, 1'b0);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    check_flags("async reset flags", 0, 3'b000);
    check("async reset pixel", {14'd0, ox[0], oy[0], ocol[0]}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    any_activity = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      any_activity = any_activity | oplot[0] | obusy[0] | odone[0];
    end
    check("quiet after reset", {31'd0, any_activity}, 32'd0);

    // Mode 3 behaves as draw.
    launch(0, 3, 1, 2, 6, 1'b0);
    expect_op(0, 3, 1, 2, 6, 4, 4, 0);

    // Right/bottom edge: clipped or wrapped depending on build.
    launch(0, 0, 158, 118, 1, 1'b0);
    expect_op(0, 0, 158, 118, 1, 4, 4, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
